// File: rtl/notas_pkg.sv
// Note table and helpers shared by the tone generator and the tone receiver.
// Bit i of every 12-bit note code corresponds to entry i of FREQ_TAB.
package notas_pkg;

    localparam int N_NOTAS   = 12;
    localparam int N_VALIDAS = 8;

    // Entries 8..11 are reserved and carry no frequency.
    localparam logic [N_NOTAS-1:0][11:0] FREQ_TAB = {
        12'd0,   12'd0,   12'd0,   12'd0,
        12'd528, 12'd495, 12'd440, 12'd396,
        12'd352, 12'd330, 12'd297, 12'd264
    };

    typedef enum logic {
        INICIAL,
        MEDINDO
    } estado_t;

    // Silence limit: twice the period of the lowest note.
    function automatic int timeout_ciclos(int clock_freq);
        return 2 * (clock_freq / int'(FREQ_TAB[0]));
    endfunction

    function automatic int largura_periodo(int clock_freq);
        return $clog2(timeout_ciclos(clock_freq) + 1);
    endfunction

    function automatic logic [N_NOTAS-1:0] one_hot(logic [3:0] idx);
        one_hot = '0;
        if (int'(idx) < N_NOTAS) one_hot[idx] = 1'b1;
    endfunction

    function automatic logic [3:0] indice_de(logic [N_NOTAS-1:0] oh);
        indice_de = '0;
        for (int i = 0; i < N_NOTAS; i++) begin
            if (oh[i]) indice_de = 4'(i);
        end
    endfunction

endpackage

// File: rtl/detector_nota_if.sv
// Signal bundle between the tone receiver and the game/recording logic.
// The period width follows the clock frequency, so both sides must agree on CLOCK_FREQ.
interface detector_nota_if #(
    parameter int CLOCK_FREQ = 50_000_000
);
    import notas_pkg::*;

    localparam int W = largura_periodo(CLOCK_FREQ);

    logic               habilita;
    logic               pulso;
    logic [N_NOTAS-1:0] nota;
    logic               valida;
    logic [W-1:0]       periodo;
    logic               nova_medida;

    modport master (
        output habilita, pulso,
        input  nota, valida, periodo, nova_medida
    );

    modport slave (
        input  habilita, pulso,
        output nota, valida, periodo, nova_medida
    );

endinterface

// File: rtl/classificador_periodo.sv
// Combinational match of a measured period against the note windows.
// Windows are fixed at elaboration; with TOL below 3 they cannot overlap.
module classificador_periodo
    import notas_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int TOL        = 2,
    parameter int W          = 19
) (
    input  logic [W-1:0] periodo,
    output logic         casou,
    output logic [3:0]   indice
);

    logic [N_VALIDAS-1:0] hit;

    for (genvar i = 0; i < N_VALIDAS; i++) begin : g_janela
        localparam int P = CLOCK_FREQ / int'(FREQ_TAB[i]);
        localparam int D = P * TOL / 100;
        localparam logic [W-1:0] LO = W'(P - D);
        localparam logic [W-1:0] HI = W'(P + D);
        assign hit[i] = (periodo >= LO) && (periodo <= HI);
    end

    always_comb begin
        casou  = |hit;
        indice = '0;
        for (int i = N_VALIDAS - 1; i >= 0; i--) begin
            if (hit[i]) indice = 4'(i);
        end
    end

endmodule

// File: rtl/detector_nota.sv
// Tone receiver: measures the period of pulso and decodes it to a one-hot note,
// reporting it as valid only after N_CONF consecutive matching periods.
//
// state   | meaning
// INICIAL | idle, counter at 0, waiting for the first rising edge
// MEDINDO | counting cycles since the last rising edge
module detector_nota
    import notas_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int TOL        = 2,
    parameter int N_CONF     = 2
) (
    input logic            clock,
    input logic            reset,
    detector_nota_if.slave bus
);

    localparam int TIMEOUT = timeout_ciclos(CLOCK_FREQ);
    localparam int W       = largura_periodo(CLOCK_FREQ);
    localparam int CW      = $clog2(N_CONF + 1);
    localparam logic [W-1:0]  CNT_MAX  = W'(TIMEOUT);
    localparam logic [CW-1:0] CONF_MAX = CW'(N_CONF);

    estado_t            estado, estado_next;
    logic [W-1:0]       contador, contador_next;
    logic [W-1:0]       periodo, periodo_next;
    logic               nova_medida, nova_medida_next;
    logic               sync_a, sync_b, sync_c, borda;
    logic               expirou;
    logic               limpa;
    logic               casou;
    logic [3:0]         indice;
    logic [3:0]         cand, cand_next;
    logic [CW-1:0]      conf, conf_next;
    logic [N_NOTAS-1:0] nota, nota_next;
    logic               valida, valida_next;

    assign limpa = reset | ~bus.habilita;

    // The synchronizer ignores habilita so no stale level produces a false edge on re-enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            sync_c <= 1'b0;
        end else begin
            sync_a <= bus.pulso;
            sync_b <= sync_a;
            sync_c <= sync_b;
        end
    end

    always_ff @(posedge clock) begin
        if (limpa) borda <= 1'b0;
        else       borda <= sync_b & ~sync_c;
    end

    always_ff @(posedge clock) begin
        if (limpa) begin
            estado      <= INICIAL;
            contador    <= '0;
            periodo     <= '0;
            nova_medida <= 1'b0;
        end else begin
            estado      <= estado_next;
            contador    <= contador_next;
            periodo     <= periodo_next;
            nova_medida <= nova_medida_next;
        end
    end

    // An edge arriving on the saturated count still wins over the timeout.
    always_comb begin
        estado_next      = estado;
        contador_next    = contador;
        periodo_next     = periodo;
        nova_medida_next = 1'b0;
        expirou          = 1'b0;
        case (estado)
            INICIAL: begin
                contador_next = '0;
                if (borda) begin
                    contador_next = W'(1);
                    estado_next   = MEDINDO;
                end
            end
            MEDINDO: begin
                if (borda) begin
                    periodo_next     = contador;
                    nova_medida_next = 1'b1;
                    contador_next    = W'(1);
                end else if (contador == CNT_MAX) begin
                    expirou       = 1'b1;
                    contador_next = '0;
                    estado_next   = INICIAL;
                end else begin
                    contador_next = contador + 1'b1;
                end
            end
            default: estado_next = INICIAL;
        endcase
    end

    classificador_periodo #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .TOL        (TOL),
        .W          (W)
    ) u_classificador (
        .periodo (periodo),
        .casou   (casou),
        .indice  (indice)
    );

    always_comb begin
        cand_next   = cand;
        conf_next   = conf;
        nota_next   = nota;
        valida_next = valida;
        if (expirou) begin
            cand_next   = '0;
            conf_next   = '0;
            nota_next   = '0;
            valida_next = 1'b0;
        end else if (nova_medida) begin
            if (!casou) begin
                conf_next   = '0;
                nota_next   = '0;
                valida_next = 1'b0;
            end else begin
                if (indice == cand && conf != '0) begin
                    conf_next = (conf == CONF_MAX) ? CONF_MAX : conf + 1'b1;
                end else begin
                    cand_next = indice;
                    conf_next = CW'(1);
                end
                if (conf_next == CONF_MAX) begin
                    nota_next   = one_hot(cand_next);
                    valida_next = 1'b1;
                end else begin
                    nota_next   = '0;
                    valida_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (limpa) begin
            cand   <= '0;
            conf   <= '0;
            nota   <= '0;
            valida <= 1'b0;
        end else begin
            cand   <= cand_next;
            conf   <= conf_next;
            nota   <= nota_next;
            valida <= valida_next;
        end
    end

    assign bus.nota        = nota;
    assign bus.valida      = valida;
    assign bus.periodo     = periodo;
    assign bus.nova_medida = nova_medida;

endmodule
